// File: rtl/audio_seq_pkg.sv
// Shared types and widths for the audio sample sequencer.
package audio_seq_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    HALF0     = 3'd3,
    HALF1     = 3'd4,
    ADVANCE   = 3'd5,
    DONE      = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Playback word-address register: reload, step up/down with range wrap, and end-of-range flag.
module seq_addr_gen #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(20'h7FFFF)
) (
  input  logic              clock50,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic              reverse,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next address: reload to the direction's range start, or step with wrap.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = reverse ? END_ADDR : START_ADDR;
    end else if (step) begin
      if (reverse) begin
        addr_d = (addr_q == START_ADDR) ? END_ADDR : (addr_q - ONE);
      end else begin
        addr_d = (addr_q == END_ADDR) ? START_ADDR : (addr_q + ONE);
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clock50) begin
    if (!rstn) begin
      addr_q <= START_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr   = addr_q;
  assign at_end = reverse ? (addr_q == START_ADDR) : (addr_q == END_ADDR);

endmodule

// File: rtl/audio_sample_sequencer.sv
// Prefetches 32-bit words over Avalon-MM and emits one 16-bit half per sample tick.
// Build option LOOP_PLAYBACK_EN: wrap at the range end instead of stopping with done.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(20'h7FFFF)
) (
  input  logic                clock50,
  input  logic                rstn,
  input  logic                sample_tick,
  input  logic                play,
  input  logic                reverse,
  input  logic                restart,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_waitrequest,
  input  logic [WORD_W-1:0]   mem_readdata,
  input  logic                mem_readdatavalid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                overrun,
  output logic                done
);

`ifdef LOOP_PLAYBACK_EN
  localparam logic STOP_AT_END = 1'b0;
`else
  localparam logic STOP_AT_END = 1'b1;
`endif

  seq_state_t          state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                dir_q, dir_d;
  logic                tick_pend_q, tick_pend_d;
  logic                restart_pend_q, restart_pend_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                done_q, done_d;
  logic                restart_now, in_half, consume, apply_restart;
  logic                addr_load, addr_step, addr_dir, at_end;

  // Next-state, tick bookkeeping and sample selection.
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    sample_d       = sample_q;
    dir_d          = dir_q;
    tick_pend_d    = tick_pend_q;
    restart_pend_d = restart_pend_q | restart;
    valid_d        = 1'b0;
    overrun_d      = 1'b0;
    done_d         = done_q;
    apply_restart  = 1'b0;
    addr_step      = 1'b0;
    restart_now    = restart | restart_pend_q;
    in_half        = (state_q == HALF0) || (state_q == HALF1);
    consume        = in_half & play & (sample_tick | tick_pend_q) & ~restart_now;

    // A tick coinciding with restart is dropped; paused halves ignore ticks.
    if (restart || (state_q == DONE)) begin
      tick_pend_d = tick_pend_q;
    end else if (in_half) begin
      if (consume) begin
        tick_pend_d = sample_tick & tick_pend_q;
      end else begin
        tick_pend_d = tick_pend_q;
      end
    end else if (sample_tick) begin
      if (tick_pend_q) begin
        overrun_d = 1'b1;
      end else begin
        tick_pend_d = 1'b1;
      end
    end else begin
      tick_pend_d = tick_pend_q;
    end

    case (state_q)
      IDLE: begin
        if (restart_now) begin
          apply_restart = 1'b1;
        end else if (play) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!mem_waitrequest) begin
          state_d = WAIT_DATA;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT_DATA: begin
        // A pending restart discards the returning word rather than playing it.
        if (mem_readdatavalid) begin
          if (restart_now) begin
            apply_restart = 1'b1;
          end else begin
            word_d  = mem_readdata;
            dir_d   = reverse;
            state_d = HALF0;
          end
        end else begin
          state_d = WAIT_DATA;
        end
      end
      HALF0: begin
        if (restart_now) begin
          apply_restart = 1'b1;
        end else if (consume) begin
          sample_d = dir_q ? word_q[WORD_W-1:SAMPLE_W] : word_q[SAMPLE_W-1:0];
          valid_d  = 1'b1;
          state_d  = HALF1;
        end else begin
          state_d = HALF0;
        end
      end
      HALF1: begin
        if (restart_now) begin
          apply_restart = 1'b1;
        end else if (consume) begin
          sample_d = dir_q ? word_q[SAMPLE_W-1:0] : word_q[WORD_W-1:SAMPLE_W];
          valid_d  = 1'b1;
          if (STOP_AT_END && at_end) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ADVANCE;
          end
        end else begin
          state_d = HALF1;
        end
      end
      ADVANCE: begin
        if (restart_now) begin
          apply_restart = 1'b1;
        end else begin
          addr_step = 1'b1;
          state_d   = FETCH;
        end
      end
      DONE: begin
        if (restart_now) begin
          apply_restart = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply_restart) begin
      word_d         = {WORD_W{1'b0}};
      tick_pend_d    = 1'b0;
      restart_pend_d = 1'b0;
      done_d         = 1'b0;
      state_d        = FETCH;
    end else begin
      restart_pend_d = restart_pend_q | restart;
    end

    addr_load = apply_restart;
    addr_dir  = apply_restart ? reverse : dir_q;
  end

  // State and output registers.
  always_ff @(posedge clock50) begin
    if (!rstn) begin
      state_q        <= IDLE;
      word_q         <= {WORD_W{1'b0}};
      sample_q       <= {SAMPLE_W{1'b0}};
      dir_q          <= 1'b0;
      tick_pend_q    <= 1'b0;
      restart_pend_q <= 1'b0;
      valid_q        <= 1'b0;
      overrun_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      sample_q       <= sample_d;
      dir_q          <= dir_d;
      tick_pend_q    <= tick_pend_d;
      restart_pend_q <= restart_pend_d;
      valid_q        <= valid_d;
      overrun_q      <= overrun_d;
      done_q         <= done_d;
    end
  end

  seq_addr_gen #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_gen (
    .clock50 (clock50),
    .rstn    (rstn),
    .load    (addr_load),
    .step    (addr_step),
    .reverse (addr_dir),
    .addr    (mem_addr),
    .at_end  (at_end)
  );

  assign mem_read     = (state_q == FETCH);
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign done         = done_q & STOP_AT_END;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer with a 4-word playback range and an Avalon memory model.
module tb_audio_sample_sequencer;

  logic        clock50 = 1'b0;
  logic        rstn, sample_tick, play, reverse, restart;
  logic        mem_read, mem_waitrequest, mem_readdatavalid;
  logic [22:0] mem_addr;
  logic [31:0] mem_readdata;
  logic [15:0] sample_out;
  logic        sample_valid, overrun, done;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  int          read_log[$];
  logic [31:0] mem [4];
  int          stall_cnt = 0;
  int          rsp_delay = 0;

  typedef struct {
    bit          rev;
    logic [31:0] word;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t vecs[4];

  audio_sample_sequencer #(
    .ADDR_W     (23),
    .START_ADDR (23'h0),
    .END_ADDR   (23'h3)
  ) dut (
    .clock50           (clock50),
    .rstn              (rstn),
    .sample_tick       (sample_tick),
    .play              (play),
    .reverse           (reverse),
    .restart           (restart),
    .mem_read          (mem_read),
    .mem_addr          (mem_addr),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .overrun           (overrun),
    .done              (done)
  );

  always #5 clock50 = ~clock50;

  task automatic step();
    @(posedge clock50);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Avalon slave model: accepts when not stalled, returns data after rsp_delay cycles.
  initial begin
    bit          accept;
    bit          busy;
    int          cnt;
    logic [22:0] a;
    logic [22:0] ra;
    busy = 1'b0;
    cnt  = 0;
    ra   = 23'h0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = 32'h0;
    forever begin
      @(negedge clock50);
      accept = (mem_read === 1'b1) && (mem_waitrequest === 1'b0);
      a      = mem_addr;
      @(posedge clock50);
      #1;
      mem_readdatavalid = 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem[ra[1:0]];
          busy              = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (accept) begin
        read_log.push_back(int'(a));
        if (rsp_delay == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem[a[1:0]];
        end else begin
          busy = 1'b1;
          cnt  = rsp_delay - 1;
          ra   = a;
        end
      end
      if (stall_cnt > 0) begin
        mem_waitrequest = 1'b1;
        stall_cnt--;
      end else begin
        mem_waitrequest = 1'b0;
      end
    end
  end

  // Scoreboard: every sample_valid pulse must match the oldest expected sample.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clock50);
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sample_unexpected: got %h expected no sample", sample_out);
        end else begin
          e = exp_q.pop_front();
          chk("sample_data", 32'(sample_out), 32'(e));
        end
      end
    end
  end

  task automatic do_tick(input bit push, input logic [15:0] val, input bit vnow,
                         input bit ovr, input string nm);
    if (push) exp_q.push_back(val);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk({nm, "_valid"}, 32'(sample_valid), 32'(vnow));
    chk({nm, "_overrun"}, 32'(overrun), 32'(ovr));
  endtask

  task automatic wait_word(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (mem_readdatavalid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got no readdatavalid expected one within 50 cycles", nm);
    end
  endtask

  task automatic begin_range(input bit rev);
    play = 1'b0;
    repeat (10) step();
    read_log.delete();
    reverse = rev;
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_done_clr", 32'(done), 32'd0);
    wait_word("begin");
    step();
  endtask

  task automatic range_run(input bit rev);
    int          a;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) mem[i] = {16'hC000 | 16'(i), 16'h3000 | 16'(i)};
    begin_range(rev);
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = rev ? 3 - k : k;
      chk("run_addr", (read_log.size() > k) ? read_log[k] : -1, a);
      w = mem[a];
      do_tick(1'b1, rev ? w[31:16] : w[15:0], 1'b1, 1'b0, "run_h0");
      do_tick(1'b1, rev ? w[15:0] : w[31:16], 1'b1, 1'b0, "run_h1");
      if (k < 3) begin
        wait_word("run");
        step();
      end
    end
`ifdef LOOP_PLAYBACK_EN
    chk("run_done", 32'(done), 32'd0);
    wait_word("wrap");
    chk("run_wrap_addr", (read_log.size() > 4) ? read_log[4] : -1, rev ? 3 : 0);
`else
    chk("run_done", 32'(done), 32'd1);
    repeat (10) step();
    chk("run_no_read", read_log.size(), 4);
    do_tick(1'b0, 16'h0, 1'b0, 1'b0, "done_tick");
    chk("run_done_hold", 32'(done), 32'd1);
`endif
  endtask

  initial begin
    int wait_n;
    rstn        = 1'b0;
    play        = 1'b0;
    reverse     = 1'b0;
    restart     = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    vecs[0] = '{1'b0, 32'hBEEF_1234, 16'h1234, 16'hBEEF};
    vecs[1] = '{1'b1, 32'hBEEF_1234, 16'hBEEF, 16'h1234};
    vecs[2] = '{1'b0, 32'h0000_FFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 32'hA5A5_5A5A, 16'hA5A5, 16'h5A5A};

    repeat (3) step();
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_sample_out", 32'(sample_out), 32'd0);
    chk("reset_valid", 32'(sample_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rstn = 1'b1;
    step();

    // Half order per direction for a handful of words.
    for (int i = 0; i < 4; i++) begin
      mem[0] = vecs[i].word;
      mem[3] = vecs[i].word;
      begin_range(vecs[i].rev);
      chk("tbl_addr", (read_log.size() > 0) ? read_log[0] : -1, vecs[i].rev ? 3 : 0);
      play = 1'b1;
      do_tick(1'b1, vecs[i].e0, 1'b1, 1'b0, "tbl_h0");
      do_tick(1'b1, vecs[i].e1, 1'b1, 1'b0, "tbl_h1");
    end

    range_run(1'b0);
    range_run(1'b1);

    // Stall: one tick pends, the next overruns; address held.
    begin_range(1'b0);
    play = 1'b1;
    do_tick(1'b1, 16'h3000, 1'b1, 1'b0, "st_h0");
    do_tick(1'b1, 16'hC000, 1'b1, 1'b0, "st_h1");
    stall_cnt = 10;
    step();
    do_tick(1'b1, 16'h3001, 1'b0, 1'b0, "st_pend");
    do_tick(1'b0, 16'h0, 1'b0, 1'b1, "st_ovr");
    chk("st_mem_read", 32'(mem_read), 32'd1);
    chk("st_addr", 32'(mem_addr), 32'd1);
    wait_word("st");
    repeat (3) step();
    chk("st_pend_served", exp_q.size(), 0);
    do_tick(1'b1, 16'hC001, 1'b1, 1'b0, "st_h1b");

    // Restart while data outstanding: word discarded, refetch from start.
    begin_range(1'b0);
    play = 1'b1;
    do_tick(1'b1, 16'h3000, 1'b1, 1'b0, "rs_h0a");
    do_tick(1'b1, 16'hC000, 1'b1, 1'b0, "rs_h1a");
    rsp_delay = 5;
    wait_n = 0;
    while (read_log.size() < 2 && wait_n < 50) begin
      step();
      wait_n++;
    end
    chk("rs_second_read", read_log.size(), 2);
    restart = 1'b1;
    step();
    restart   = 1'b0;
    rsp_delay = 0;
    wait_word("rs_discard");
    wait_word("rs_new");
    chk("rs_addr", (read_log.size() > 2) ? read_log[2] : -1, 0);
    step();
    do_tick(1'b1, 16'h3000, 1'b1, 1'b0, "rs_h0");

    // Pause inside HALF1.
    begin_range(1'b0);
    play = 1'b1;
    do_tick(1'b1, 16'h3000, 1'b1, 1'b0, "p_h0");
    play = 1'b0;
    for (int i = 0; i < 3; i++) do_tick(1'b0, 16'h0, 1'b0, 1'b0, "p_paused");
    play = 1'b1;
    do_tick(1'b1, 16'hC000, 1'b1, 1'b0, "p_h1");

    // Reset while a read is stalled.
    begin_range(1'b0);
    play = 1'b1;
    do_tick(1'b1, 16'h3000, 1'b1, 1'b0, "r_h0");
    do_tick(1'b1, 16'hC000, 1'b1, 1'b0, "r_h1");
    stall_cnt = 10;
    step();
    step();
    chk("rst_pre_read", 32'(mem_read), 32'd1);
    rstn = 1'b0;
    step();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    play      = 1'b0;
    stall_cnt = 0;
    step();
    rstn = 1'b1;
    repeat (5) step();
    chk("rst_idle", 32'(mem_read), 32'd0);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
